// File: rtl/fp_max_unpool_2x2.sv
// 2x2 max-unpooling stage: each pooled word plus its argmax index expands into
// four raster-ordered beats, the value at the argmax slot and FILL_VALUE elsewhere.
module fp_max_unpool_2x2 #(
    parameter logic [31:0] FILL_VALUE = 32'h0000_0000,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [1:0]       in_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [1:0]       out_pos,
    output logic             out_last,
    output logic [CNT_W-1:0] win_count
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [0:0]       state_reg;
    logic [1:0]       beat_reg;
    logic [1:0]       idx_reg;
    logic [31:0]      data_reg;
    logic [CNT_W-1:0] win_count_reg;

    logic emitting;
    logic last_beat;
    logic in_fire;
    logic out_fire;

    assign emitting  = (state_reg == EMIT);
    assign last_beat = emitting && (beat_reg == 2'd3);

    // Accepting on the final beat lets back-to-back windows stream without a bubble.
    assign in_ready  = !emitting || (last_beat && out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = emitting && out_ready;

    assign out_valid = emitting;
    assign out_pos   = beat_reg;
    assign out_last  = last_beat;
    assign out_data  = !emitting              ? 32'h0000_0000 :
                       (beat_reg == idx_reg)  ? data_reg      : FILL_VALUE;
    assign win_count = win_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            beat_reg  <= 2'd0;
            idx_reg   <= 2'd0;
            data_reg  <= 32'h0000_0000;
        end else if (in_fire) begin
            state_reg <= EMIT;
            beat_reg  <= 2'd0;
            idx_reg   <= in_idx;
            data_reg  <= in_data;
        end else if (out_fire) begin
            if (last_beat) begin
                state_reg <= IDLE;
                beat_reg  <= 2'd0;
            end else begin
                beat_reg  <= beat_reg + 2'd1;
            end
        end
    end

    // Counts completed windows only; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_count_reg <= '0;
        end else if (out_fire && last_beat) begin
            win_count_reg <= win_count_reg + 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_max_unpool_2x2.sv
// Randomized bench for fp_max_unpool_2x2: a queue of expected beats per accepted
// window predicts every output; a second instance covers fill value and counter wrap.
module tb_fp_max_unpool_2x2;

    typedef struct packed {
        logic [1:0]  pos;
        logic [1:0]  idx;
        logic [31:0] data;
    } beat_t;

    localparam logic [31:0] FILL_B = 32'hFF80_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic [1:0]  in_idx = 2'd0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_last;
    logic [31:0] out_data;
    logic [1:0]  out_pos;
    logic [15:0] win_count;

    logic        in_ready_b, out_valid_b, out_last_b;
    logic [31:0] out_data_b;
    logic [1:0]  out_pos_b;
    logic [1:0]  win_count_b;

    int total = 0;
    int bad   = 0;
    int wins  = 0;
    beat_t q[$];

    always #5 clk = ~clk;

    fp_max_unpool_2x2 dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_idx(in_idx),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_pos(out_pos), .out_last(out_last), .win_count(win_count)
    );

    fp_max_unpool_2x2 #(.FILL_VALUE(FILL_B), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_idx(in_idx),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_pos(out_pos_b), .out_last(out_last_b), .win_count(win_count_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check predicted outputs, then advance the model.
    task automatic step(input logic iv, input logic [31:0] d, input logic [1:0] ix,
                        input logic ordy, output logic accepted);
        logic  mv, exp_ir, ofire, ifire;
        beat_t b;
        @(negedge clk);
        in_valid = iv; in_data = d; in_idx = ix; out_ready = ordy;
        #1;
        mv     = (q.size() != 0);
        exp_ir = !mv || ((q[0].pos == 2'd3) && ordy);
        check_eq("out_valid", {31'd0, out_valid}, {31'd0, mv});
        check_eq("out_valid_b", {31'd0, out_valid_b}, {31'd0, mv});
        check_eq("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
        check_eq("in_ready_b", {31'd0, in_ready_b}, {31'd0, exp_ir});
        if (mv) begin
            b = q[0];
            check_eq("out_pos", {30'd0, out_pos}, {30'd0, b.pos});
            check_eq("out_last", {31'd0, out_last}, {31'd0, b.pos == 2'd3});
            check_eq("out_data", out_data, (b.pos == b.idx) ? b.data : 32'h0);
            check_eq("out_data_b", out_data_b, (b.pos == b.idx) ? b.data : FILL_B);
            check_eq("out_pos_b", {30'd0, out_pos_b}, {30'd0, b.pos});
        end
        ofire = mv && ordy;
        ifire = iv && exp_ir;
        accepted = ifire;
        @(posedge clk);
        #1;
        if (ofire) begin
            if (q[0].pos == 2'd3) wins++;
            void'(q.pop_front());
        end
        if (ifire) begin
            for (int p = 0; p < 4; p++) begin
                b.pos = 2'(p); b.idx = ix; b.data = d;
                q.push_back(b);
            end
        end
        check_eq("win_count", {16'd0, win_count}, 32'(wins % 65536));
        check_eq("win_count_b", {30'd0, win_count_b}, 32'(wins % 4));
    endtask

    task automatic drain();
        logic acc;
        int   n = 0;
        while (q.size() != 0 && n < 50) begin
            step(1'b0, $urandom, 2'($urandom), 1'b1, acc);
            n++;
        end
        check_eq("drain_empty", q.size(), 0);
    endtask

    // Offer one window until accepted, with out_ready drawn from a pattern.
    task automatic send(input logic [31:0] d, input logic [1:0] ix, input logic ordy);
        logic acc = 1'b0;
        int   n = 0;
        while (!acc && n < 50) begin
            step(1'b1, d, ix, ordy, acc);
            n++;
        end
        check_eq("send_accepted", {31'd0, acc}, 32'd1);
    endtask

    initial begin
        logic        acc;
        int          k, n, vcount, ph;
        logic [31:0] specials [4];
        specials[0] = 32'h7FC0_0001; specials[1] = 32'h8000_0000;
        specials[2] = 32'h7F80_0000; specials[3] = 32'h0000_0001;

        #2;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_data", out_data, 32'h0);
        check_eq("rst_win_count", {16'd0, win_count}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_out_pos", {30'd0, out_pos}, 32'd0);

        // Single window, argmax at BL.
        send(32'h4049_0FDB, 2'd2, 1'b1);
        drain();
        check_eq("w1_count", {16'd0, win_count}, 32'd1);

        // Four windows back-to-back with in_valid held high.
        k = 0; n = 0; vcount = 0;
        while (k < 4 && n < 40) begin
            step(1'b1, 32'h3F80_0000 + 32'(k), 2'(k), 1'b1, acc);
            if (acc) k++;
            n++;
        end
        while (q.size() != 0 && n < 60) begin
            #0;
            if (out_valid) vcount++;
            step(1'b0, 32'h0, 2'd0, 1'b1, acc);
            n++;
        end
        check_eq("b2b_count", {16'd0, win_count}, 32'd5);

        // Stalled window: out_ready pattern 1,0,0,1,...
        send(32'hFF80_0000, 2'd3, 1'b1);
        ph = 0;
        while (q.size() != 0 && ph < 60) begin
            step(1'b0, $urandom, 2'($urandom), (ph % 3) == 0, acc);
            ph++;
        end

        // Special IEEE values pass through untouched.
        for (int i = 0; i < 4; i++) begin
            send(specials[i], 2'(i), 1'b1);
        end
        drain();

        // Asynchronous reset after the pos1 beat has transferred.
        send(32'h1234_5678, 2'd1, 1'b1);
        step(1'b0, 32'h0, 2'd0, 1'b1, acc);
        step(1'b0, 32'h0, 2'd0, 1'b1, acc);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("arst_out_data", out_data, 32'h0);
        check_eq("arst_win_count", {16'd0, win_count}, 32'd0);
        check_eq("arst_win_count_b", {30'd0, win_count_b}, 32'd0);
        q.delete();
        wins = 0;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;

        // Five windows: the 2-bit counter on the second instance wraps to 1.
        for (int i = 0; i < 5; i++) begin
            send($urandom, 2'($urandom), 1'b1);
        end
        drain();
        check_eq("wrap_count_b", {30'd0, win_count_b}, 32'd1);
        check_eq("wrap_count", {16'd0, win_count}, 32'd5);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] d;
            d = ($urandom_range(0, 7) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            step($urandom_range(0, 9) < 7, d, 2'($urandom), $urandom_range(0, 9) < 6, acc);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
